// File: rtl/xhci_mem_arbiter.sv
// xHCI memory channel arbiter: round-robin ownership of one shared rd/wr
// engine pair, with drain-to-idle before re-arbitration.
//
// Ports:
//   clk                 in   clock, all state on posedge
//   rst                 in   asynchronous active-low reset
//   req                 in   [NREQ] per-requester channel claim
//   up_rd_has_request   in   [NREQ] per-requester read strobe
//   up_wr_has_data      in   [NREQ] per-requester write strobe
//   dn_idle             in   shared engines idle
//   grant               out  [NREQ] one-hot ownership (registered)
//   owner               out  index of current / last owner
//   busy                out  arbiter not idle
//   dn_rd_has_request   out  owner's read strobe
//   dn_wr_has_data      out  owner's write strobe
//   wd_timeout          out  watchdog expiry pulse
//
// Build option: XHCI_ARB_WATCHDOG_EN enables the ownership watchdog;
// without it wd_timeout is tied low and ownership is unbounded.
module xhci_mem_arbiter #(
  parameter int NREQ      = 4,
  parameter int WD_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         up_rd_has_request,
  input  logic [NREQ-1:0]         up_wr_has_data,
  input  logic                    dn_idle,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    dn_rd_has_request,
  output logic                    dn_wr_has_data,
  output logic                    wd_timeout
);

  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_OWN   = 2'd1;
  localparam logic [1:0] ARB_DRAIN = 2'd2;

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            own_req;
  logic            in_own;

  assign own_req = req[owner_q];
  assign in_own  = (state_q == ARB_OWN);

  // Rotating search: last+1 first, wrapping, last owner checked last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = last_q;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef XHCI_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WD_CYCLES) + 1;

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wd_q;
  logic          wd_hit;
  logic          wd_fire;

  assign wd_hit = (wd_cnt_q == CW'(WD_CYCLES - 1));

  // Counter is zero outside ARB_OWN, so entry always starts at zero.
  always_comb begin
    wd_cnt_d = '0;
    if (in_own && state_d == ARB_OWN) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= '0;
      wd_q     <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_q     <= wd_fire;
    end
  end

  assign wd_timeout = wd_q;
`else
  assign wd_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef XHCI_ARB_WATCHDOG_EN
    wd_fire = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (win_vld) begin
          state_d = ARB_OWN;
          owner_d = win_idx;
          grant_d = ONE << win_idx;
        end
      end
      ARB_OWN: begin
        // A voluntary release takes priority over a watchdog expiry.
        if (!own_req) begin
          state_d = ARB_DRAIN;
          grant_d = '0;
        end
`ifdef XHCI_ARB_WATCHDOG_EN
        else if (wd_hit) begin
          state_d = ARB_DRAIN;
          grant_d = '0;
          last_d  = owner_q;
          wd_fire = 1'b1;
        end
`endif
      end
      ARB_DRAIN: begin
        if (dn_idle) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = (state_q != ARB_IDLE);

  // Strobes follow state_q, so an async reset clears them at once.
  assign dn_rd_has_request = in_own & up_rd_has_request[owner_q];
  assign dn_wr_has_data    = in_own & up_wr_has_data[owner_q];

endmodule

// File: tb/tb_xhci_mem_arbiter.sv
// Self-checking bench for xhci_mem_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_xhci_mem_arbiter;

  localparam int NREQ = 4;
  localparam int WD   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] up_rd = '0;
  logic [3:0] up_wr = '0;
  logic       dn_idle = 1'b1;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       dn_rd;
  logic       dn_wr;
  logic       wd_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xhci_mem_arbiter #(.NREQ(NREQ), .WD_CYCLES(WD)) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .up_rd_has_request (up_rd),
    .up_wr_has_data    (up_wr),
    .dn_idle           (dn_idle),
    .grant             (grant),
    .owner             (owner),
    .busy              (busy),
    .dn_rd_has_request (dn_rd),
    .dn_wr_has_data    (dn_wr),
    .wd_timeout        (wd_timeout)
  );

  // Reference model: who owns the channel, in which phase, who went last.
  typedef enum int {M_IDLE, M_OWN, M_DRAIN} mph_t;
  mph_t m_ph;
  int   m_owner;
  int   m_last;
  int   m_cnt;
  bit   m_wd;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ph    = M_IDLE;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_cnt   = 0;
    m_wd    = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic di);
    int w;
    m_wd = 1'b0;
    case (m_ph)
      M_IDLE: begin
        w = pick(r, m_last);
        if (w >= 0) begin
          m_ph    = M_OWN;
          m_owner = w;
          m_cnt   = 1;
        end
      end
      M_OWN: begin
        if (!r[m_owner]) m_ph = M_DRAIN;
`ifdef XHCI_ARB_WATCHDOG_EN
        else if (m_cnt == WD) begin
          m_ph   = M_DRAIN;
          m_wd   = 1'b1;
          m_last = m_owner;
        end
`endif
        else m_cnt++;
      end
      default: begin
        if (di) begin
          m_ph   = M_IDLE;
          m_last = m_owner;
        end
      end
    endcase
  endfunction

  function automatic logic [3:0] exp_grant();
    return (m_ph == M_OWN) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic exp_rd();
    return (m_ph == M_OWN) ? up_rd[m_owner] : 1'b0;
  endfunction

  function automatic logic exp_wr();
    return (m_ph == M_OWN) ? up_wr[m_owner] : 1'b0;
  endfunction

  function automatic logic [1:0] exp_owner();
    return 2'(m_owner);
  endfunction

  task automatic tick();
    logic [3:0] r;
    logic       di;
    @(posedge clk);
    r  = req;
    di = dn_idle;
    if (!rst) model_reset();
    else model_step(r, di);
    #1;
  endtask

  task automatic test_reset();
    up_rd = 4'b1111;
    up_wr = 4'b1111;
    req   = 4'b1111;
    model_reset();
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL reset_grant got=%b want=0000", grant);
    end
    checks++;
    if (owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_owner got=%0d want=0", owner);
    end
    checks++;
    if (busy !== 1'b0 || dn_rd !== 1'b0 || dn_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b rd=%b wr=%b want=000", busy, dn_rd, dn_wr);
    end
    checks++;
    if (wd_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_wd got=%b want=0", wd_timeout);
    end
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold_grant got=%b want=0000", grant);
    end
    req   = '0;
    up_rd = '0;
    up_wr = '0;
    rst   = 1'b1;
  endtask

  task automatic test_rr_basic();
    req = 4'b0101;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL rr_pre_grant got=%b want=0000", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || grant !== exp_grant()) begin
      errors++;
      $display("FAIL rr_first_grant got=%b want=0001", grant);
    end
    checks++;
    if (owner !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rr_first_owner owner=%0d busy=%b want=0,1", owner, busy);
    end
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rr_drain grant=%b busy=%b want=0000,1", grant, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL rr_idle_gap busy=%b grant=%b want=0,0000", busy, grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2 || grant !== exp_grant()) begin
      errors++;
      $display("FAIL rr_second_grant grant=%b owner=%0d want=0100,2", grant, owner);
    end
  endtask

  task automatic test_wrap();
    req = 4'b1000;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 4'b1000 || owner !== 2'd3) begin
      errors++;
      $display("FAIL wrap_own3 grant=%b owner=%0d want=1000,3", grant, owner);
    end
    req = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_hold grant=%b want=1000", grant);
    end
    req = 4'b0001;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0 || grant !== exp_grant()) begin
      errors++;
      $display("FAIL wrap_to0 grant=%b owner=%0d want=0001,0", grant, owner);
    end
  endtask

  task automatic test_forward();
    req = 4'b0010;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010 || owner !== 2'd1) begin
      errors++;
      $display("FAIL fwd_own1 grant=%b owner=%0d want=0010,1", grant, owner);
    end
    up_rd = 4'b0101;
    #1;
    checks++;
    if (dn_rd !== 1'b0) begin
      errors++;
      $display("FAIL fwd_rd_other got=%b want=0", dn_rd);
    end
    up_rd = 4'b0111;
    #1;
    checks++;
    if (dn_rd !== 1'b1) begin
      errors++;
      $display("FAIL fwd_rd_owner got=%b want=1", dn_rd);
    end
    up_wr = 4'b1101;
    #1;
    checks++;
    if (dn_wr !== 1'b0) begin
      errors++;
      $display("FAIL fwd_wr_other got=%b want=0", dn_wr);
    end
    up_wr = 4'b0010;
    #1;
    checks++;
    if (dn_wr !== 1'b1) begin
      errors++;
      $display("FAIL fwd_wr_owner got=%b want=1", dn_wr);
    end
    req   = 4'b0000;
    up_rd = 4'b1111;
    up_wr = 4'b1111;
    tick();
    checks++;
    if (dn_rd !== 1'b0 || dn_wr !== 1'b0) begin
      errors++;
      $display("FAIL fwd_drain_mask rd=%b wr=%b want=0,0", dn_rd, dn_wr);
    end
    tick();
  endtask

  task automatic test_drain_wait();
    req = 4'b0101;
    tick();
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL drw_own2 grant=%b owner=%0d want=0100,2", grant, owner);
    end
    // owner drops while bit 3 rises; engines stay busy for a while
    req     = 4'b1001;
    dn_idle = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) req = 4'b1101;
      checks++;
      if (busy !== 1'b1 || grant !== 4'b0000 || dn_rd !== 1'b0 || dn_wr !== 1'b0) begin
        errors++;
        $display("FAIL drw_cycle%0d busy=%b grant=%b rd=%b wr=%b want=1,0000,0,0", i, busy, grant, dn_rd, dn_wr);
      end
    end
    dn_idle = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drw_idle busy=%b want=0", busy);
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || owner !== 2'd3) begin
      errors++;
      $display("FAIL drw_pending grant=%b owner=%0d want=1000,3", grant, owner);
    end
    req = 4'b0101;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL drw_next grant=%b owner=%0d want=0001,0", grant, owner);
    end
    req = 4'b0100;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 4'b0100 || grant !== exp_grant()) begin
      errors++;
      $display("FAIL drw_own2b grant=%b want=0100", grant);
    end
  endtask

  task automatic test_reset_mid();
    up_rd = 4'b1111;
    up_wr = 4'b1111;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (grant !== 4'b0000 || dn_rd !== 1'b0 || dn_wr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async grant=%b rd=%b wr=%b busy=%b want=0", grant, dn_rd, dn_wr, busy);
    end
    tick();
    rst = 1'b1;
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0010 || owner !== 2'd1 || grant !== exp_grant()) begin
      errors++;
      $display("FAIL rstmid_regrant grant=%b owner=%0d want=0010,1", grant, owner);
    end
  endtask

  task automatic test_watchdog();
    int pulses;
    pulses = 0;
    for (int i = 0; i < WD + 6; i++) begin
      tick();
      if (wd_timeout === 1'b1) pulses++;
      checks++;
      if (grant !== exp_grant() || wd_timeout !== m_wd || busy !== (m_ph != M_IDLE)) begin
        errors++;
        $display("FAIL wd_cycle%0d grant=%b wd=%b busy=%b want=%b,%b", i, grant, wd_timeout, busy, exp_grant(), m_wd);
      end
    end
`ifdef XHCI_ARB_WATCHDOG_EN
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL wd_pulses got=%0d want=1", pulses);
    end
`else
    checks++;
    if (pulses != 0 || grant !== 4'b0010) begin
      errors++;
      $display("FAIL wd_disabled pulses=%0d grant=%b want=0,0010", pulses, grant);
    end
`endif
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      end
      up_rd   = 4'($urandom);
      up_wr   = 4'($urandom);
      dn_idle = ($urandom_range(3) != 0);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(499) == 0) begin
        rst = 1'b0;
        model_reset();
      end
      #1;
      checks++;
      if (dn_rd !== exp_rd() || dn_wr !== exp_wr()) begin
        errors++;
        $display("FAIL rnd_strobe n=%0d rd=%b wr=%b want=%b,%b", n, dn_rd, dn_wr, exp_rd(), exp_wr());
      end
      tick();
      checks++;
      if (grant !== exp_grant() || owner !== exp_owner() || busy !== (m_ph != M_IDLE) || wd_timeout !== m_wd) begin
        errors++;
        $display("FAIL rnd_state n=%0d grant=%b owner=%0d busy=%b wd=%b want=%b,%0d,%b,%b", n, grant, owner, busy, wd_timeout, exp_grant(), m_owner, m_ph != M_IDLE, m_wd);
      end
      checks++;
      if ($countones(grant) > 1) begin
        errors++;
        $display("FAIL rnd_onehot n=%0d grant=%b want=at most one bit", n, grant);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rr_basic();
    test_wrap();
    test_forward();
    test_drain_wait();
    test_reset_mid();
    test_watchdog();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xhci_mem_arbiter.md
XHCI_MEM_ARBITER -- requirements
Module: xhci_mem_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one memory read/write channel pair (2..8).
REQ-002 Parameter: WD_CYCLES, default 4096, watchdog limit in clk cycles for one ownership period.
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-005 req  in  NREQ  per-requester channel claim; held high for the whole transaction.
REQ-006 up_rd_has_request  in  NREQ  per-requester read-request strobe.
REQ-007 up_wr_has_data  in  NREQ  per-requester write-request strobe.
REQ-008 dn_idle  in  1  high when the shared read and write engines are both in their idle state.
REQ-009 grant  out  NREQ  one-hot ownership, registered.
REQ-010 owner  out  $clog2(NREQ)  index of current or last owner.
REQ-011 busy  out  1  high whenever the FSM is not ARB_IDLE.
REQ-012 dn_rd_has_request  out  1  forwarded read strobe of the owner.
REQ-013 dn_wr_has_data  out  1  forwarded write strobe of the owner.
REQ-014 wd_timeout  out  1  one-cycle pulse on watchdog expiry; present only with the REQ-030 macro.

Function
REQ-015 FSM states: ARB_IDLE, ARB_OWN, ARB_DRAIN.
REQ-016 ARB_IDLE: if any req bit high, select the winner by round robin, register grant/owner, go to ARB_OWN next cycle; otherwise stay.
REQ-017 Round robin: search starts at last_owner+1, wraps from NREQ-1 to 0, and last_owner itself is checked last.
REQ-018 Grant latency: exactly 1 cycle from req sampled high in ARB_IDLE to grant high.
REQ-019 ARB_OWN: dn_rd_has_request = up_rd_has_request[owner], dn_wr_has_data = up_wr_has_data[owner], combinational; non-owner strobes ignored.
REQ-020 ARB_OWN: req[owner] sampled low -> ARB_DRAIN; grant clears in the same transition.
REQ-021 ARB_DRAIN: both downstream strobes forced 0; dn_idle high -> ARB_IDLE, last_owner <= owner.
REQ-022 Minimum one ARB_IDLE cycle between consecutive grants; no back-to-back re-grant without it.
REQ-023 grant is never multi-hot; grant is zero outside ARB_OWN.
REQ-024 Other req bits rising during ARB_OWN/ARB_DRAIN are held pending and arbitrated only in ARB_IDLE.
REQ-025 Owner dropping req in the same cycle another rises -> drain first; the new request wins only after ARB_IDLE.
REQ-026 req[owner] high again during ARB_DRAIN is ignored until ARB_IDLE and then competes as lowest priority.
REQ-027 owner holds its value through ARB_DRAIN and ARB_IDLE until the next grant.

Reset
REQ-028 rst low: state ARB_IDLE, grant 0, owner 0, last_owner NREQ-1 (first search starts at 0), busy 0, downstream strobes 0, wd_timeout 0, watchdog counter 0.
REQ-029 Reset mid-ownership drops grant and downstream strobes asynchronously; no drain performed; first post-reset grant follows REQ-016.

Configuration
REQ-030 Macro XHCI_ARB_WATCHDOG_EN defined: counter cleared on entry to ARB_OWN, increments each ARB_OWN cycle; at WD_CYCLES-1 force ARB_DRAIN, pulse wd_timeout for 1 cycle, last_owner <= owner.
REQ-031 Macro undefined: no counter, wd_timeout port tied 0, ARB_OWN held indefinitely while req[owner] high.

Verification
REQ-032 req=4'b0101 from reset -> grant 4'b0001 next cycle, then after release+dn_idle grant 4'b0100 (round robin).
REQ-033 Owner 3 releases while req=4'b1001 -> after ARB_IDLE grant 4'b0001 (wrap 3->0), owner=0.
REQ-034 In ARB_OWN owner 1, up_rd_has_request=4'b0101 -> dn_rd_has_request=0; set bit 1 -> dn_rd_has_request=1 same cycle.
REQ-035 Release with dn_idle=0 for 5 cycles -> stays ARB_DRAIN 5 cycles, strobes 0, busy 1, then ARB_IDLE.
REQ-036 rst low for 1 cycle mid-ownership -> grant 0 and strobes 0 immediately; req=4'b0010 after rst high -> grant 4'b0010.
REQ-037 XHCI_ARB_WATCHDOG_EN, WD_CYCLES=16, owner holds req -> wd_timeout pulse at cycle 16 of ownership, grant 0, ARB_DRAIN.
